// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: streams sequential words from a zero-latency
// memory port into a small FIFO, with flush-and-restart on redirect.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    mem_en_read,
  output logic [31:0]             mem_addr,
  input  logic [WORD_W-1:0]       mem_rd_data,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [WORD_W-1:0]       inst_data,
  output logic [31:0]             inst_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [31:0]     MemLast  = 32'(MEM_WORDS - 1);
  localparam logic [31:0]     MemWords = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFull
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [WORD_W-1:0] data_mem_q [DEPTH];
  logic [31:0]       pc_mem_q   [DEPTH];

  logic              push;
  logic              pop;
  logic [31:0]       fetch_pc_inc;

  // Handshake and memory-port outputs
  always_comb begin
    inst_valid  = (count_q != '0) && !redirect_valid;
    pop         = inst_valid && inst_ready;
    // A full buffer may still fetch when the head leaves in the same cycle.
    mem_en_read = !redirect_valid && (state_q != StIdle) && ((count_q < DepthCnt) || pop);
    push        = mem_en_read;
    mem_addr    = mem_en_read ? fetch_pc_q : 32'd0;
    inst_data   = data_mem_q[rd_ptr_q];
    inst_pc     = pc_mem_q[rd_ptr_q];
    count       = count_q;
  end

  assign fetch_pc_inc = (fetch_pc_q >= MemLast) ? 32'd0 : fetch_pc_q + 32'd1;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_valid) begin
      // Flush wins over everything except reset.
      state_d    = StFetch;
      count_d    = '0;
      fetch_pc_d = redirect_pc % MemWords;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        fetch_pc_d = fetch_pc_inc;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase

      case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StFetch;
            fetch_pc_d = 32'd0;
          end
        end
        StFetch: begin
          if ((count_d == DepthCnt) && !pop) begin
            state_d = StFull;
          end
        end
        StFull: begin
          if (pop) begin
            state_d = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      fetch_pc_q <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= mem_rd_data;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_prefetch_buffer;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MEM_WORDS = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              mem_en_read;
  logic [31:0]       mem_addr;
  logic [WORD_W-1:0] mem_rd_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [WORD_W-1:0] inst_data;
  logic [31:0]       inst_pc;
  logic [2:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int unsigned m_q[$];
  int unsigned m_fpc;
  bit          m_idle;
  bit          exp_valid, exp_pop, exp_en;
  logic        cur_rst, cur_start, cur_rv, cur_rdy;
  logic [31:0] cur_rpc;

  instr_prefetch_buffer #(
    .DEPTH     (DEPTH),
    .WORD_W    (WORD_W),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_en_read    (mem_en_read),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .count          (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000 + addr;
  endfunction

  assign mem_rd_data = mem_word(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, then compare outputs against the model.
  task automatic drive(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_n = rst; start = st; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    cur_rst = rst; cur_start = st; cur_rv = rv; cur_rpc = rpc; cur_rdy = rdy;
    #1;
    exp_valid = (m_q.size() != 0) && !rv;
    exp_pop   = exp_valid && rdy;
    exp_en    = !rv && !m_idle && ((m_q.size() < DEPTH) || exp_pop);
    check_eq("count", 32'(count), 32'(m_q.size()));
    check_eq("inst_valid", 32'(inst_valid), 32'(exp_valid));
    check_eq("mem_en_read", 32'(mem_en_read), 32'(exp_en));
    check_eq("mem_addr", mem_addr, exp_en ? m_fpc : 32'd0);
    if (m_q.size() != 0) begin
      check_eq("inst_pc", inst_pc, m_q[0]);
      check_eq("inst_data", inst_data, mem_word(m_q[0]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur_rst) begin
      m_q.delete();
      m_fpc  = 0;
      m_idle = 1'b1;
    end else if (cur_rv) begin
      m_q.delete();
      m_fpc  = cur_rpc % MEM_WORDS;
      m_idle = 1'b0;
    end else begin
      if (exp_pop) void'(m_q.pop_front());
      if (exp_en) begin
        m_q.push_back(m_fpc);
        m_fpc = (m_fpc + 1) % MEM_WORDS;
      end
      if (m_idle && cur_start) begin
        m_idle = 1'b0;
        m_fpc  = 0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    drive(rst, st, rv, rpc, rdy);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_q.delete(); m_fpc = 0; m_idle = 1'b1;

    // Reset state
    drive(1, 0, 0, 0, 0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_en", 32'(mem_en_read), 32'd0);
    tick();

    // Fill with consumer stalled
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0);
      check_eq("fill_en", 32'(mem_en_read), 32'd1);
      check_eq("fill_addr", mem_addr, 32'(i));
      tick();
    end
    drive(1, 0, 0, 0, 0);
    check_eq("full_en", 32'(mem_en_read), 32'd0);
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_data", inst_data, 32'h1000);
    check_eq("full_pc", inst_pc, 32'd0);
    tick();

    // Pop while full: same-cycle push at address 4
    drive(1, 0, 0, 0, 1);
    check_eq("fullpop_en", 32'(mem_en_read), 32'd1);
    check_eq("fullpop_addr", mem_addr, 32'd4);
    tick();
    drive(1, 0, 0, 0, 0);
    check_eq("fullpop_count", 32'(count), 32'd4);
    check_eq("fullpop_pc", inst_pc, 32'd1);
    tick();

    // Streaming with consumer always ready
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    check_eq("stream_first_valid", 32'(inst_valid), 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 0, 1);
      check_eq("stream_valid", 32'(inst_valid), 32'd1);
      check_eq("stream_pc", inst_pc, 32'(k));
      check_eq("stream_data", inst_data, 32'h1000 + 32'(k));
      tick();
    end

    // Redirect with three entries buffered, landing near the wrap point
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    drive(1, 0, 1, 32'h7E, 0);
    check_eq("redir_valid", 32'(inst_valid), 32'd0);
    tick();
    drive(1, 0, 0, 0, 1);
    check_eq("redir_count", 32'(count), 32'd0);
    check_eq("redir_addr", mem_addr, 32'h7E);
    tick();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] want;
      want = (32'h7E + 32'(k)) % 32'd128;
      drive(1, 0, 0, 0, 1);
      check_eq("redir_pc", inst_pc, want);
      tick();
    end

    // Reset mid-fetch with two entries buffered
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check_eq("pre_rst_count", 32'(count), 32'd2);
    tick();
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 1);
      check_eq("post_rst_count", 32'(count), 32'd0);
      check_eq("post_rst_valid", 32'(inst_valid), 32'd0);
      check_eq("post_rst_en", 32'(mem_en_read), 32'd0);
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 10000; c++) begin
      logic rst, st, rv, rdy;
      logic [31:0] rpc;
      rst = ($urandom_range(999) != 0);
      st  = ($urandom_range(3) == 0);
      rv  = ($urandom_range(39) == 0);
      rdy = ($urandom_range(3) != 0);
      rpc = $urandom();
      if ($urandom_range(1) == 0) rpc = rpc % 32'd128;
      drive(rst, st, rv, rpc, rdy);
      check_eq("count_bound", 32'(count <= 3'd4), 32'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
